// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed DIGITS-digit 7-segment driver.
// Scans one digit per REFRESH_DIV clocks, double-buffers the displayed
// value so a frame is never torn, optionally blanks leading zeros and
// applies pin polarity as the very last step.
// DIGITS must be 1..8 and REFRESH_DIV must be >= 2.

// Per-digit glyph lane: hex nibble -> active-high {g,f,e,d,c,b,a},
// forced dark when the caller says this digit is a blanked leading zero.
module seg7_digit_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] glyph
);

  // Hex decode, then blanking override.
  always_comb begin
    glyph = 7'h00;
    unique case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    if (blank) glyph = 7'h00;
  end

endmodule

module seg7_mux_driver #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  // Scan state
  logic [PW-1:0] prescaler;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  // Double buffer: shadow collects loads, active is what is on the glass.
  logic [4*DIGITS-1:0] shadow_val, active_val;
  logic [DIGITS-1:0]   shadow_dp,  active_dp;
  logic                pending;

  // Decode fabric
  logic [DIGITS-1:0][3:0] act_nib;
  logic [DIGITS-1:0]      lz;
  logic [DIGITS-1:0][6:0] glyphs;
  logic [6:0]             glyph_sel;
  logic                   dp_sel;
  logic [DIGITS-1:0]      an_sel;

  assign tick    = enable && (prescaler == PS_LAST);
  assign wrap    = tick && (idx == IDX_LAST);
  assign act_nib = active_val;

  // Prescaler and digit index; both parked at 0 while disabled so a
  // re-enable always starts at digit 0 with a full dwell period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Load path: the latest load lands in shadow; active only changes on
  // the scan wrap. A load coinciding with the wrap bypasses shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
      if (wrap) begin
        active_val <= value;
        active_dp  <= dp_in;
        pending    <= 1'b0;
      end else begin
        pending    <= 1'b1;
      end
    end else if (wrap && pending) begin
      active_val <= shadow_val;
      active_dp  <= shadow_dp;
      pending    <= 1'b0;
    end
  end

  // Leading-zero flags: lz[k] set when nibbles DIGITS-1..k are all zero.
  // Digit 0 is never blanked, so lz[0] stays 0.
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run   = run && (act_nib[k] == 4'h0);
      lz[k] = run;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    seg7_digit_lane u_lane (
      .nib   (act_nib[k]),
      .blank (blank_lz && lz[k]),
      .glyph (glyphs[k])
    );
  end

  // Select the glyph, decimal point and anode for the current index.
  always_comb begin
    glyph_sel = 7'h00;
    dp_sel    = 1'b0;
    an_sel    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        glyph_sel = glyphs[k];
        dp_sel    = active_dp[k];
        an_sel[k] = 1'b1;
      end
    end
  end

  // Registered pins, one cycle behind idx; polarity applied last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= {7{SEG_INV}};
      dp         <= SEG_INV;
      an         <= {DIGITS{AN_INV}};
      frame_done <= 1'b0;
    end else if (!enable) begin
      seg        <= {7{SEG_INV}};
      dp         <= SEG_INV;
      an         <= {DIGITS{AN_INV}};
      frame_done <= 1'b0;
    end else begin
      seg        <= glyph_sel ^ {7{SEG_INV}};
      dp         <= dp_sel ^ SEG_INV;
      an         <= an_sel ^ {DIGITS{AN_INV}};
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: DIGITS=4, REFRESH_DIV=4, with a
// second instance using inverted pin polarity sharing all inputs.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst_n, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n, fd, fd_n;
  logic [3:0]  an, an_n;

  int nchecks = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(fd));

  seg7_mux_driver #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_n), .dp(dp_n), .an(an_n), .frame_done(fd_n));

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Park the scan for one edge, then re-enable: next edge is scan cycle 1.
  task automatic restart();
    enable = 1'b0; step(); enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b1; load = 1'b0; blank_lz = 1'b0;
    value = 16'h0; dp_in = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    nchecks++; if (an !== 4'h0)    begin nfail++; $display("FAIL reset_an got %b want 0000", an); end
    nchecks++; if (seg !== 7'h00)  begin nfail++; $display("FAIL reset_seg got %h want 00", seg); end
    nchecks++; if (dp !== 1'b0)    begin nfail++; $display("FAIL reset_dp got %b want 0", dp); end
    nchecks++; if (fd !== 1'b0)    begin nfail++; $display("FAIL reset_fd got %b want 0", fd); end
    nchecks++; if (an_n !== 4'hF)  begin nfail++; $display("FAIL reset_an_n got %b want 1111", an_n); end
    nchecks++; if (seg_n !== 7'h7F) begin nfail++; $display("FAIL reset_seg_n got %h want 7f", seg_n); end
    nchecks++; if (dp_n !== 1'b1)  begin nfail++; $display("FAIL reset_dp_n got %b want 1", dp_n); end
    step(); step();
    nchecks++; if (an !== 4'h0)    begin nfail++; $display("FAIL reset_hold_an got %b want 0000", an); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic       efd;
    for (int c = 1; c <= 32; c++) begin
      step();
      ea  = 4'(1 << (((c - 1) / 4) % 4));
      efd = (c % 16 == 0);
      nchecks++; if (an !== ea)     begin nfail++; $display("FAIL scan_an c=%0d got %b want %b", c, an, ea); end
      nchecks++; if (seg !== 7'h3F) begin nfail++; $display("FAIL scan_seg c=%0d got %h want 3f", c, seg); end
      nchecks++; if (dp !== 1'b0)   begin nfail++; $display("FAIL scan_dp c=%0d got %b want 0", c, dp); end
      nchecks++; if (fd !== efd)    begin nfail++; $display("FAIL scan_fd c=%0d got %b want %b", c, fd, efd); end
    end
  endtask

  task automatic test_load_mid_frame();
    logic [6:0] tbl [4];
    logic [6:0] es;
    logic [3:0] ea;
    logic       edp;
    int         d;
    tbl = '{7'h71, 7'h77, 7'h5B, 7'h06};
    restart();
    for (int c = 1; c <= 32; c++) begin
      if (c == 7) begin value = 16'h12AF; dp_in = 4'b0100; load = 1'b1; end
      step();
      load = 1'b0;
      d   = ((c - 1) / 4) % 4;
      ea  = 4'(1 << d);
      es  = (c <= 16) ? 7'h3F : tbl[d];
      edp = (c > 16) && (d == 2);
      nchecks++; if (an !== ea)   begin nfail++; $display("FAIL load_an c=%0d got %b want %b", c, an, ea); end
      nchecks++; if (seg !== es)  begin nfail++; $display("FAIL load_seg c=%0d got %h want %h", c, seg, es); end
      nchecks++; if (dp !== edp)  begin nfail++; $display("FAIL load_dp c=%0d got %b want %b", c, dp, edp); end
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] t1 [4];
    logic [6:0] t2 [4];
    logic [6:0] es;
    logic [3:0] ea;
    int         d;
    t1 = '{7'h3F, 7'h07, 7'h00, 7'h00};
    t2 = '{7'h3F, 7'h00, 7'h00, 7'h00};
    blank_lz = 1'b1;
    restart();
    for (int c = 1; c <= 48; c++) begin
      if (c == 1)  begin value = 16'h0070; dp_in = 4'b0000; load = 1'b1; end
      if (c == 20) begin value = 16'h0000; dp_in = 4'b0000; load = 1'b1; end
      step();
      load = 1'b0;
      d  = ((c - 1) / 4) % 4;
      ea = 4'(1 << d);
      nchecks++; if (an !== ea) begin nfail++; $display("FAIL blank_an c=%0d got %b want %b", c, an, ea); end
      if (c > 16) begin
        es = (c <= 32) ? t1[d] : t2[d];
        nchecks++; if (seg !== es)  begin nfail++; $display("FAIL blank_seg c=%0d got %h want %h", c, seg, es); end
        nchecks++; if (dp !== 1'b0) begin nfail++; $display("FAIL blank_dp c=%0d got %b want 0", c, dp); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] es;
    logic       efd;
    restart();
    for (int c = 1; c <= 48; c++) begin
      if (c == 3)  begin value = 16'h1111; dp_in = 4'h0; load = 1'b1; end
      if (c == 9)  begin value = 16'h2222; dp_in = 4'h0; load = 1'b1; end
      if (c == 16) begin value = 16'h3333; dp_in = 4'h0; load = 1'b1; end
      step();
      load = 1'b0;
      es  = (c <= 16) ? 7'h3F : 7'h4F;
      efd = (c % 16 == 0);
      nchecks++; if (seg !== es) begin nfail++; $display("FAIL b2b_seg c=%0d got %h want %h", c, seg, es); end
      nchecks++; if (fd !== efd) begin nfail++; $display("FAIL b2b_fd c=%0d got %b want %b", c, fd, efd); end
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] ea;
    restart();
    for (int c = 1; c <= 6; c++) step();
    nchecks++; if (an !== 4'b0010) begin nfail++; $display("FAIL en_pre_an got %b want 0010", an); end
    enable = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      step();
      nchecks++; if (an !== 4'h0)   begin nfail++; $display("FAIL en_off_an c=%0d got %b want 0000", c, an); end
      nchecks++; if (seg !== 7'h00) begin nfail++; $display("FAIL en_off_seg c=%0d got %h want 00", c, seg); end
      nchecks++; if (dp !== 1'b0)   begin nfail++; $display("FAIL en_off_dp c=%0d got %b want 0", c, dp); end
      nchecks++; if (fd !== 1'b0)   begin nfail++; $display("FAIL en_off_fd c=%0d got %b want 0", c, fd); end
    end
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      ea = (c <= 4) ? 4'b0001 : 4'b0010;
      nchecks++; if (an !== ea)     begin nfail++; $display("FAIL en_on_an c=%0d got %b want %b", c, an, ea); end
      nchecks++; if (seg !== 7'h4F) begin nfail++; $display("FAIL en_on_seg c=%0d got %h want 4f", c, seg); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] ea;
    logic       efd;
    restart();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin value = 16'h5678; dp_in = 4'hF; load = 1'b1; end
      step();
      load = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    nchecks++; if (an !== 4'h0)     begin nfail++; $display("FAIL arst_an got %b want 0000", an); end
    nchecks++; if (seg !== 7'h00)   begin nfail++; $display("FAIL arst_seg got %h want 00", seg); end
    nchecks++; if (dp !== 1'b0)     begin nfail++; $display("FAIL arst_dp got %b want 0", dp); end
    nchecks++; if (an_n !== 4'hF)   begin nfail++; $display("FAIL arst_an_n got %b want 1111", an_n); end
    nchecks++; if (seg_n !== 7'h7F) begin nfail++; $display("FAIL arst_seg_n got %h want 7f", seg_n); end
    nchecks++; if (dp_n !== 1'b1)   begin nfail++; $display("FAIL arst_dp_n got %b want 1", dp_n); end
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      ea  = 4'(1 << (((c - 1) / 4) % 4));
      efd = (c == 16);
      nchecks++; if (an !== ea)      begin nfail++; $display("FAIL arst_post_an c=%0d got %b want %b", c, an, ea); end
      nchecks++; if (seg !== 7'h3F)  begin nfail++; $display("FAIL arst_post_seg c=%0d got %h want 3f", c, seg); end
      nchecks++; if (dp !== 1'b0)    begin nfail++; $display("FAIL arst_post_dp c=%0d got %b want 0", c, dp); end
      nchecks++; if (an_n !== ~ea)   begin nfail++; $display("FAIL arst_post_an_n c=%0d got %b want %b", c, an_n, ~ea); end
      nchecks++; if (seg_n !== 7'h40) begin nfail++; $display("FAIL arst_post_seg_n c=%0d got %h want 40", c, seg_n); end
      nchecks++; if (dp_n !== 1'b1)  begin nfail++; $display("FAIL arst_post_dp_n c=%0d got %b want 1", c, dp_n); end
      nchecks++; if (fd_n !== efd)   begin nfail++; $display("FAIL arst_post_fd_n c=%0d got %b want %b", c, fd_n, efd); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_mid_frame();
    test_blank_lz();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
